// File: rtl/cgra_config_loader_if.sv
// Narrow configuration beat stream into the CGRA config loader.
// The source drives data/valid; the loader drives ready.
interface cgra_config_loader_if #(
  parameter int IN_W = 4
);
  logic [IN_W-1:0] data;
  logic            valid;
  logic            ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cgra_config_loader.sv
// Assembles beats into per-PE control words in a staging buffer and commits
// them to the array in one cycle, so the PEs never see a partial configuration.
//
// state  | meaning
// IDLE   | no load in progress, array frozen
// LOAD   | accepting beats into staging, array frozen
// COMMIT | one cycle, staging copied to pe_ctrl at its closing edge
// RUN    | configuration valid, pe_en follows run_en
module cgra_config_loader #(
  parameter int NUM_PE = 4,
  parameter int CTRL_W = 8,
  parameter int IN_W   = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  cgra_config_loader_if.slave      i_cfg,
  input  logic                     i_run_en,
  output logic [NUM_PE*CTRL_W-1:0] o_pe_ctrl,
  output logic                     o_pe_en,
  output logic                     o_busy,
  output logic                     o_config_done
);
  localparam int BEATS = CTRL_W / IN_W;
  localparam int BC_W  = $clog2(BEATS) + 1;
  localparam int WI_W  = $clog2(NUM_PE) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_RUN} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [BC_W-1:0]           r_beat_cnt;
  logic [WI_W-1:0]           r_word_idx;
  logic [CTRL_W-1:0]         r_word_buf;
  logic [NUM_PE*CTRL_W-1:0]  r_staging;
  logic [NUM_PE*CTRL_W-1:0]  r_pe_ctrl;
  logic [CTRL_W-1:0]         w_word;
  logic                      w_ready;
  logic                      w_xfer;
  logic                      w_last_beat;
  logic                      w_last_word;
  logic                      w_restart;

  assign w_xfer      = i_cfg.valid && w_ready;
  assign w_last_beat = (r_beat_cnt == BC_W'(BEATS - 1));
  assign w_last_word = (r_word_idx == WI_W'(NUM_PE - 1));
  // start is ignored only in COMMIT; elsewhere it (re)opens a load
  assign w_restart   = i_start && (r_state != S_COMMIT);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_LOAD;
      S_LOAD: begin
        if (!i_start && w_xfer && w_last_beat && w_last_word)
          w_next_state = S_COMMIT;
      end
      S_COMMIT: w_next_state = S_RUN;
      S_RUN:    if (i_start) w_next_state = S_LOAD;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready       = 1'b0;
    o_busy        = 1'b0;
    o_config_done = 1'b0;
    o_pe_en       = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ready = 1'b1;
        o_busy  = 1'b1;
      end
      S_COMMIT: o_busy = 1'b1;
      S_RUN: begin
        o_config_done = 1'b1;
        o_pe_en       = i_run_en;
      end
      default: ;
    endcase
  end

  assign i_cfg.ready = w_ready;
  assign o_pe_ctrl   = r_pe_ctrl;

  // Current word with the incoming beat merged in, little-endian by beat index
  always_comb begin
    w_word = r_word_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat_cnt == BC_W'(k)) w_word[k*IN_W +: IN_W] = i_cfg.data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_beat_cnt <= '0;
      r_word_idx <= '0;
      r_word_buf <= '0;
      r_staging  <= '0;
      r_pe_ctrl  <= '0;
    end else begin
      if (w_restart) begin
        r_beat_cnt <= '0;
        r_word_idx <= '0;
      end else if (w_xfer) begin
        r_word_buf <= w_word;
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_word_idx <= r_word_idx + WI_W'(1);
          for (int i = 0; i < NUM_PE; i++) begin
            if (r_word_idx == WI_W'(i)) r_staging[i*CTRL_W +: CTRL_W] <= w_word;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + BC_W'(1);
        end
      end
      if (r_state == S_COMMIT) r_pe_ctrl <= r_staging;
    end
  end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader: loads, backpressure, restart, gating, reload.
module tb_cgra_config_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        run_en;
  logic [31:0] pe_ctrl;
  logic        pe_en;
  logic        busy;
  logic        done;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t0;

  cgra_config_loader_if #(.IN_W(4)) u_cfg ();

  cgra_config_loader #(.NUM_PE(4), .CTRL_W(8), .IN_W(4)) u_dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_cfg         (u_cfg),
    .i_run_en      (run_en),
    .o_pe_ctrl     (pe_ctrl),
    .o_pe_en       (pe_en),
    .o_busy        (busy),
    .o_config_done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input bit with_beat, input logic [3:0] b);
    start       = 1'b1;
    u_cfg.valid = with_beat;
    u_cfg.data  = b;
    step();
    start       = 1'b0;
    u_cfg.valid = 1'b0;
  endtask

  // seq holds beats first-to-last from the top nibble down
  task automatic feed(input logic [31:0] seq, input int first, input int n, input bit gap);
    logic [3:0] b;
    for (int i = first; i < first + n; i++) begin
      b = seq[(7-i)*4 +: 4];
      if (gap) begin
        u_cfg.valid = 1'b0;
        u_cfg.data  = ~b;
        step();
      end
      u_cfg.valid = 1'b1;
      u_cfg.data  = b;
      step();
    end
    u_cfg.valid = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] ctrl, input logic en,
                          input logic rdy, input logic bsy, input logic dn);
    chk({tag, ".pe_ctrl"}, pe_ctrl, ctrl);
    chk({tag, ".pe_en"}, pe_en, en);
    chk({tag, ".in_ready"}, u_cfg.ready, rdy);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".config_done"}, done, dn);
  endtask

  task automatic wait_run(input string tag, input int exp_cycles);
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".run_reached"}, done, 1'b1);
    chk({tag, ".start_to_run"}, cyc - t0, exp_cycles);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; run_en = 1'b0;
    u_cfg.valid = 1'b0; u_cfg.data = 4'h0;
    step(); step();
    chk_outs("reset_init", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    run_en = 1'b1; #1;
    chk("idle_gate.pe_en", pe_en, 1'b0);
    run_en = 1'b0;

    // streaming load
    t0 = cyc;
    do_start(1'b0, 4'h0);
    feed(32'h5A3C0F71, 0, 8, 1'b0);
    run_en = 1'b1; #1;
    chk_outs("stream_commit", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_run("stream", 10);
    chk_outs("stream_run", 32'h17F0C3A5, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset held 2 cycles mid-RUN
    rst = 1'b1;
    step(); step();
    chk_outs("reset_run", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; run_en = 1'b0;
    step();

    // backpressure on alternate cycles
    t0 = cyc;
    do_start(1'b0, 4'h0);
    feed(32'h5A3C0F71, 0, 8, 1'b1);
    chk_outs("bp_commit", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_run("bp", 18);
    chk("bp_run.pe_ctrl", pe_ctrl, 32'h17F0C3A5);

    // run gating
    run_en = 1'b1; #1; chk("gate1.pe_en", pe_en, 1'b1);
    run_en = 1'b0; #1; chk("gate0.pe_en", pe_en, 1'b0);
    run_en = 1'b1; #1; chk("gate1b.pe_en", pe_en, 1'b1);

    // reload while running
    t0 = cyc;
    do_start(1'b0, 4'h0);
    chk_outs("reload_load", 32'h17F0C3A5, 1'b0, 1'b1, 1'b1, 1'b0);
    feed(32'h6587A9CB, 0, 4, 1'b0);
    chk_outs("reload_half", 32'h17F0C3A5, 1'b0, 1'b1, 1'b1, 1'b0);
    feed(32'h6587A9CB, 4, 4, 1'b0);
    chk_outs("reload_commit", 32'h17F0C3A5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_run("reload", 10);
    chk_outs("reload_run", 32'hBC9A7856, 1'b1, 1'b0, 1'b0, 1'b1);
    run_en = 1'b0;

    // restart after 3 beats, with a beat offered on the restart cycle
    do_start(1'b0, 4'h0);
    feed(32'hEEE00000, 0, 3, 1'b0);
    t0 = cyc;
    do_start(1'b1, 4'hD);
    feed(32'h11223344, 0, 8, 1'b0);
    wait_run("restart", 10);
    chk("restart_run.pe_ctrl", pe_ctrl, 32'h44332211);

    // reset mid-LOAD discards the committed words too
    do_start(1'b0, 4'h0);
    feed(32'h12345678, 0, 3, 1'b0);
    rst = 1'b1;
    step();
    chk_outs("reset_load", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
